// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, req/gnt/rvalid instruction-memory bus, and an
// in-order instruction buffer feeding decode over valid/ready, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        res_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] fifo_wr, fifo_rd, pcq_wr, pcq_rd;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   pcq       [FIFO_DEPTH];
    logic [CW:0]   credits_used;
    logic          grant, push, pop;

    // Every granted fetch reserves a buffer slot, so the buffer can never overflow.
    assign credits_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_o    = !res_i && !redirect_i && (credits_used < DEPTH_W);
    assign imem_addr_o   = fetch_pc;
    assign grant         = imem_req_o && imem_gnt_i;
    assign push          = imem_rvalid_i && (drop == '0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = fifo_data[fifo_rd];
    assign instr_pc_o    = fifo_pc[fifo_rd];

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
                pcq[i]       <= '0;
            end
        end else if (redirect_i) begin
            // Anything still in flight after this cycle's response belongs to the old path.
            fetch_pc    <= {redirect_pc_i[31:2], 2'b00};
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            outstanding <= outstanding - CW'(imem_rvalid_i);
            drop        <= outstanding - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc    <= fetch_pc + 32'd4;
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= pcq_wr + 1'b1;
            end
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            if (imem_rvalid_i && (drop != '0))
                drop <= drop - 1'b1;
            if (push) begin
                fifo_data[fifo_wr] <= imem_rdata_i;
                fifo_pc[fifo_wr]   <= pcq[pcq_rd];
                fifo_wr            <= fifo_wr + 1'b1;
                pcq_rd             <= pcq_rd + 1'b1;
            end
            if (pop)
                fifo_rd <= fifo_rd + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/decode/redirect stimulus checked every cycle
// against a queue-level model of in-flight fetches and buffered instructions.
module tb_fetch_unit;
    localparam int D = 4;

    logic        clk_i = 1'b0;
    logic        res_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o, instr_pc_o;
    logic        instr_valid_o, instr_ready_i;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(D)) dut (
        .clk_i(clk_i), .res_i(res_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model: memory holds granted addresses (with the redirect epoch they belong to),
    // bufq holds PCs returned on the current path and not yet taken by decode.
    logic [31:0] rq_addr[$];
    int          rq_ep[$];
    logic [31:0] bufq[$];
    logic [31:0] exp_fetch;
    int          epoch;

    logic        obs_req, obs_valid, obs_grant;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle(input int gp, input int rp, input int yp,
                         input logic rd, input logic [31:0] rpc);
        logic        ereq, evalid;
        logic [31:0] head;
        int          ep;
        @(negedge clk_i);
        imem_gnt_i    = ($urandom_range(99) < gp);
        imem_rvalid_i = (rq_addr.size() > 0) && ($urandom_range(99) < rp);
        imem_rdata_i  = imem_rvalid_i ? memf(rq_addr[0]) : $urandom;
        instr_ready_i = ($urandom_range(99) < yp);
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
        ereq   = !rd && (rq_addr.size() + bufq.size() < D);
        evalid = (bufq.size() > 0);
        check("req", 32'(imem_req_o), 32'(ereq));
        if (ereq) check("addr", imem_addr_o, exp_fetch);
        check("valid", 32'(instr_valid_o), 32'(evalid));
        if (evalid) begin
            check("pc", instr_pc_o, bufq[0]);
            check("instr", instr_o, memf(bufq[0]));
        end
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_valid = instr_valid_o;
        obs_pc    = instr_pc_o;
        obs_instr = instr_o;
        obs_grant = ereq && imem_gnt_i;
        if (!rd && evalid && instr_ready_i) void'(bufq.pop_front());
        if (imem_rvalid_i) begin
            head = rq_addr.pop_front();
            ep   = rq_ep.pop_front();
            if (!rd && ep == epoch) bufq.push_back(head);
        end
        if (obs_grant) begin
            rq_addr.push_back(exp_fetch);
            rq_ep.push_back(epoch);
            exp_fetch += 32'd4;
        end
        if (rd) begin
            bufq.delete();
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        res_i         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        rq_addr.delete();
        rq_ep.delete();
        bufq.delete();
        exp_fetch = 32'h0;
        epoch     = 0;
        @(negedge clk_i);
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        @(negedge clk_i);
        res_i = 1'b0;
    endtask

    initial begin
        logic [31:0] addr_log[12];
        logic [31:0] pc_log[12];
        logic        v_log[12];
        int          grants, nfound;
        logic [31:0] last_ga;
        logic        found, found2;

        res_i = 1'b1; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;

        // Streaming: one request and one instruction per cycle after fill
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(100, 100, 100, 1'b0, 32'h0);
            addr_log[k] = obs_addr; pc_log[k] = obs_pc; v_log[k] = obs_valid;
        end
        check("t1_addr0", addr_log[0], 32'h0);
        check("t1_addr1", addr_log[1], 32'h4);
        check("t1_addr2", addr_log[2], 32'h8);
        for (int k = 2; k < 12; k++) begin
            check("t1_nobubble", 32'(v_log[k]), 32'd1);
            check("t1_pc", pc_log[k], 32'(4 * (k - 2)));
        end

        // Decode stalled: credits stop requests after exactly D grants
        do_reset();
        grants = 0; last_ga = '0;
        for (int k = 0; k < 10; k++) begin
            cycle(100, 100, 0, 1'b0, 32'h0);
            if (obs_grant) begin grants++; last_ga = obs_addr; end
        end
        check("t2_grants", 32'(grants), 32'd4);
        check("t2_last_addr", last_ga, 32'hC);
        check("t2_hold_pc", obs_pc, 32'h0);
        check("t2_hold_instr", obs_instr, memf(32'h0));
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            cycle(100, 100, 100, 1'b0, 32'h0);
            if (obs_req) begin found = 1'b1; check("t2_resume_addr", obs_addr, 32'h10); end
        end
        if (!found) check("t2_resume_timeout", 32'd0, 32'd1);

        // Grant stall: address held while waiting
        do_reset();
        cycle(100, 100, 100, 1'b0, 32'h0);
        cycle(100, 100, 100, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 100, 100, 1'b0, 32'h0);
            check("t3_req_held", 32'(obs_req), 32'd1);
            check("t3_addr_held", obs_addr, 32'h8);
        end
        cycle(100, 100, 100, 1'b0, 32'h0);
        check("t3_grant", 32'(obs_grant), 32'd1);
        check("t3_grant_addr", obs_addr, 32'h8);
        cycle(100, 100, 100, 1'b0, 32'h0);
        check("t3_next_addr", obs_addr, 32'hC);

        // Redirect with two fetches outstanding, unaligned target
        do_reset();
        cycle(100, 0, 100, 1'b0, 32'h0);
        cycle(100, 0, 100, 1'b0, 32'h0);
        cycle(100, 0, 100, 1'b1, 32'h0000_0103);
        check("t4_req_in_redirect", 32'(obs_req), 32'd0);
        found = 1'b0; found2 = 1'b0;
        for (int k = 0; k < 20 && !found2; k++) begin
            cycle(100, 100, 100, 1'b0, 32'h0);
            if (obs_req && !found) begin found = 1'b1; check("t4_first_addr", obs_addr, 32'h100); end
            if (obs_valid && !found2) begin found2 = 1'b1; check("t4_first_pc", obs_pc, 32'h100); end
        end
        if (!found2) check("t4_valid_timeout", 32'd0, 32'd1);

        // Redirect coinciding with a pop and a returning word
        do_reset();
        for (int k = 0; k < 4; k++) cycle(100, 100, 100, 1'b0, 32'h0);
        cycle(100, 100, 100, 1'b1, 32'h0000_0200);
        check("t5_pre_valid", 32'(obs_valid), 32'd1);
        check("t5_pre_rvalid", 32'(imem_rvalid_i), 32'd1);
        cycle(100, 100, 100, 1'b0, 32'h0);
        check("t5_flushed", 32'(obs_valid), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(100, 100, 100, 1'b0, 32'h0);
            if (obs_valid) begin found = 1'b1; check("t5_first_pc", obs_pc, 32'h200); end
        end
        if (!found) check("t5_valid_timeout", 32'd0, 32'd1);

        // PC wrap at the top of the address space
        do_reset();
        cycle(100, 100, 100, 1'b1, 32'hFFFF_FFFC);
        nfound = 0;
        for (int k = 0; k < 20 && nfound < 2; k++) begin
            cycle(100, 100, 100, 1'b0, 32'h0);
            if (obs_grant) begin
                check(nfound == 0 ? "t6_addr_top" : "t6_addr_wrap", obs_addr,
                      nfound == 0 ? 32'hFFFF_FFFC : 32'h0);
                nfound++;
            end
        end
        if (nfound < 2) check("t6_grant_timeout", 32'(nfound), 32'd2);

        // Random traffic, redirects and one mid-run reset
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            int gp, rp, yp;
            gp = $urandom_range(100, 20);
            rp = $urandom_range(100, 20);
            yp = $urandom_range(100, 10);
            if (seg == 8) do_reset();
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(99) < 4)
                    cycle(gp, rp, yp, 1'b1, $urandom);
                else
                    cycle(gp, rp, yp, 1'b0, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
